// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FUNCT3 encodings, FSM states
// and the small per-access decode helpers used at request time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    PETICION = 2'd1,
    FIN      = 2'd2
  } lsu_state_t;

  // Illegal FUNCT3 encodings are folded into the misaligned response.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return off[0];
      F3_W:        return (off != 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the addressed byte/half out of the
// memory word and sign- or zero-extends it according to FUNCT3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{offset_i, 3'b000} +: 8];
    half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_BU:   data_o = {24'h0, byte_v};
      F3_HU:   data_o = {16'h0, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: REPOSO -> PETICION -> FIN handshake with
// memory. Define LSU_TIMEOUT_EN to abort requests after MAX_ESPERA wait cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MAX_ESPERA = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ES_STORE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] DIRECCION,
  input  logic [31:0] DATO_W,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] DATO_R,
  output logic        VALID,
  output logic        BUSY,
  output logic        ERR_ALINEACION,
  output logic        ERR_TIMEOUT
);

  if (MAX_ESPERA < 1) begin : g_bad_max_espera
    $error("MAX_ESPERA must be at least 1");
  end

  lsu_state_t  state_q;
  logic        es_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] load_data;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_ESPERA + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_timeout_q;
  assign ERR_TIMEOUT = err_timeout_q;
`else
  assign ERR_TIMEOUT = 1'b0;
`endif

  lsu_load_align u_load_align (
    .rdata_i  (MEM_RDATA),
    .funct3_i (funct3_q),
    .offset_i (off_q),
    .data_o   (load_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= REPOSO;
      es_store_q     <= 1'b0;
      funct3_q       <= 3'b000;
      off_q          <= 2'b00;
      MEM_REQ        <= 1'b0;
      MEM_WE         <= 1'b0;
      MEM_ADDR       <= 32'h0;
      MEM_BE         <= 4'h0;
      MEM_WDATA      <= 32'h0;
      DATO_R         <= 32'h0;
      VALID          <= 1'b0;
      BUSY           <= 1'b0;
      ERR_ALINEACION <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q          <= '0;
      err_timeout_q  <= 1'b0;
`endif
    end else begin
      // Completion flags are single-cycle pulses; FIN entry re-asserts them.
      VALID          <= 1'b0;
      ERR_ALINEACION <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      err_timeout_q  <= 1'b0;
`endif
      case (state_q)
        REPOSO: begin
          if (START) begin
            es_store_q <= ES_STORE;
            funct3_q   <= FUNCT3;
            off_q      <= DIRECCION[1:0];
            BUSY       <= 1'b1;
            if (lsu_misaligned(FUNCT3, DIRECCION[1:0])) begin
              state_q        <= FIN;
              VALID          <= 1'b1;
              ERR_ALINEACION <= 1'b1;
              DATO_R         <= 32'h0;
            end else begin
              state_q   <= PETICION;
              MEM_REQ   <= 1'b1;
              MEM_WE    <= ES_STORE;
              MEM_ADDR  <= {DIRECCION[31:2], 2'b00};
              MEM_BE    <= lsu_byte_en(FUNCT3, DIRECCION[1:0]);
              MEM_WDATA <= lsu_wdata(FUNCT3, DATO_W);
`ifdef LSU_TIMEOUT_EN
              cnt_q     <= '0;
`endif
            end
          end
        end
        PETICION: begin
          if (MEM_ACK) begin
            state_q <= FIN;
            MEM_REQ <= 1'b0;
            VALID   <= 1'b1;
            DATO_R  <= es_store_q ? 32'h0 : load_data;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == CNT_W'(MAX_ESPERA - 1)) begin
            state_q       <= FIN;
            MEM_REQ       <= 1'b0;
            VALID         <= 1'b1;
            err_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        FIN: begin
          state_q <= REPOSO;
          BUSY    <= 1'b0;
        end
        default: begin
          state_q <= REPOSO;
          BUSY    <= 1'b0;
          MEM_REQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-lane arithmetic model,
// plus the directed scenarios (alignment, ignored START, reset, timeout).
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        ES_STORE;
  logic [2:0]  FUNCT3;
  logic [31:0] DIRECCION;
  logic [31:0] DATO_W;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic [31:0] DATO_R;
  logic        VALID;
  logic        BUSY;
  logic        ERR_ALINEACION;
  logic        ERR_TIMEOUT;

  load_store_unit #(.MAX_ESPERA(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ES_STORE(ES_STORE), .FUNCT3(FUNCT3),
    .DIRECCION(DIRECCION), .DATO_W(DATO_W), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA), .DATO_R(DATO_R), .VALID(VALID), .BUSY(BUSY),
    .ERR_ALINEACION(ERR_ALINEACION), .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_dr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for an illegal encoding.
  function automatic int model_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_bad(input logic [2:0] f3, input logic [31:0] a);
    int s = model_size(f3);
    return (s == 0) || ((a % s) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int s = model_size(f3);
    int lanes = (s == 4) ? 15 : (s == 2) ? 3 : 1;
    return 4'(lanes * (1 << (a % 4)));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int s = model_size(f3);
    if (s == 1) return (d & 32'hFF) * 32'h01010101;
    if (s == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int s = model_size(f3);
    logic [31:0] mask, v, top;
    if (s == 4) return rd;
    mask = (s == 1) ? 32'hFF : 32'hFFFF;
    top  = (s == 1) ? 32'h80 : 32'h8000;
    v = (rd >> (8 * (a % 4))) & mask;
    if (f3 < 3'd4 && v >= top) v = v | ~mask;
    return v;
  endfunction

  // One transaction: k wait cycles before ACK; extra drives a competing START
  // in the first PETICION cycle and in the FIN cycle.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int k,
                         input bit extra);
    bit bad = model_bad(f3, a);
    exp_q.push_back(bad ? 32'h0 : (st ? 32'h0 : model_load(f3, a, rd)));
    @(negedge CLK);
    START = 1'b1; ES_STORE = st; FUNCT3 = f3; DIRECCION = a; DATO_W = wd;
    @(negedge CLK);
    START = 1'b0; ES_STORE = $urandom_range(0, 1); FUNCT3 = 3'($urandom_range(0, 7));
    DIRECCION = $urandom; DATO_W = $urandom;
    if (!bad) begin
      for (int w = 0; w <= k; w++) begin
        check_eq("req", {31'h0, MEM_REQ}, 32'h1);
        check_eq("we", {31'h0, MEM_WE}, {31'h0, st});
        check_eq("addr", MEM_ADDR, a & 32'hFFFF_FFFC);
        check_eq("be", {28'h0, MEM_BE}, {28'h0, model_be(f3, a)});
        if (st) check_eq("wdata", MEM_WDATA, model_wdata(f3, wd));
        check_eq("valid_wait", {31'h0, VALID}, 32'h0);
        check_eq("dato_r_hold", DATO_R, last_dr);
        MEM_ACK   = (w == k);
        MEM_RDATA = (w == k) ? rd : $urandom;
        START     = extra && (w == 0);
        FUNCT3    = 3'd0;
        @(negedge CLK);
        START = 1'b0; MEM_ACK = 1'b0; MEM_RDATA = $urandom;
      end
    end
    check_eq("valid", {31'h0, VALID}, 32'h1);
    check_eq("err_al", {31'h0, ERR_ALINEACION}, {31'h0, bad});
    check_eq("err_to", {31'h0, ERR_TIMEOUT}, 32'h0);
    check_eq("req_fin", {31'h0, MEM_REQ}, 32'h0);
    check_eq("dato_r", DATO_R, exp_q.pop_front());
    last_dr = DATO_R;
    START = extra; FUNCT3 = 3'd0; DIRECCION = $urandom;
    @(negedge CLK);
    START = 1'b0;
    check_eq("busy_idle", {31'h0, BUSY}, 32'h0);
    check_eq("req_idle", {31'h0, MEM_REQ}, 32'h0);
    check_eq("valid_idle", {31'h0, VALID}, 32'h0);
    check_eq("err_idle", {30'h0, ERR_ALINEACION, ERR_TIMEOUT}, 32'h0);
  endtask

  localparam logic [2:0] ST_F3 [8] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
  localparam logic [2:0] LD_F3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};

  initial begin
    RST = 1'b1; START = 1'b0; ES_STORE = 1'b0; FUNCT3 = 3'd0; DIRECCION = 32'h0;
    DATO_W = 32'h0; MEM_ACK = 1'b0; MEM_RDATA = 32'h0; last_dr = 32'h0;
    repeat (3) @(negedge CLK);
    check_eq("rst_ctrl", {25'h0, MEM_REQ, MEM_WE, VALID, BUSY, ERR_ALINEACION, ERR_TIMEOUT, 1'b0}, 32'h0);
    check_eq("rst_be", {28'h0, MEM_BE}, 32'h0);
    check_eq("rst_addr", MEM_ADDR, 32'h0);
    check_eq("rst_wdata", MEM_WDATA, 32'h0);
    check_eq("rst_dato_r", DATO_R, 32'h0);
    RST = 1'b0;

    // Directed: LB sign-extended lane 3, SH with waits, misaligned LW, LHU + extra START.
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1'b0);
    check_eq("lb_const", DATO_R, 32'hFFFF_FF80);
    run_txn(1'b1, 3'b001, 32'h0000_0002, 32'h0000_BEEF, 32'h1234_5678, 3, 1'b0);
    check_eq("sh_const", DATO_R, 32'h0);
    run_txn(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0, 1'b0);
    check_eq("lw_mis_const", DATO_R, 32'h0);
    run_txn(1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h9ABC_0000, 2, 1'b1);
    check_eq("lhu_const", DATO_R, 32'h0000_9ABC);

    for (int i = 0; i < 60; i++) begin
      logic st;
      logic [2:0] f3;
      st = 1'($urandom_range(0, 1));
      f3 = st ? ST_F3[$urandom_range(0, 7)] : LD_F3[$urandom_range(0, 7)];
      run_txn(st, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0));
    end

    // Reset during PETICION with a coincident ACK must drop the access.
    @(negedge CLK);
    START = 1'b1; ES_STORE = 1'b0; FUNCT3 = 3'b010; DIRECCION = 32'h0000_0010;
    @(negedge CLK);
    START = 1'b0;
    check_eq("rst_mid_req", {31'h0, MEM_REQ}, 32'h1);
    RST = 1'b1; MEM_ACK = 1'b1; MEM_RDATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    RST = 1'b0; MEM_ACK = 1'b0;
    check_eq("rst_mid_busy", {31'h0, BUSY}, 32'h0);
    check_eq("rst_mid_req0", {31'h0, MEM_REQ}, 32'h0);
    check_eq("rst_mid_valid", {31'h0, VALID}, 32'h0);
    check_eq("rst_mid_dato_r", DATO_R, 32'h0);
    last_dr = 32'h0;
    @(negedge CLK);
    check_eq("rst_mid_valid2", {31'h0, VALID}, 32'h0);

`ifdef LSU_TIMEOUT_EN
    run_txn(1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h1357_9BDF, 1, 1'b0);
    @(negedge CLK);
    START = 1'b1; ES_STORE = 1'b0; FUNCT3 = 3'b010; DIRECCION = 32'h0000_0040;
    @(negedge CLK);
    START = 1'b0;
    for (int w = 0; w < 4; w++) begin
      check_eq("to_req", {31'h0, MEM_REQ}, 32'h1);
      check_eq("to_valid_wait", {31'h0, VALID}, 32'h0);
      @(negedge CLK);
    end
    check_eq("to_valid", {31'h0, VALID}, 32'h1);
    check_eq("to_err", {31'h0, ERR_TIMEOUT}, 32'h1);
    check_eq("to_err_al", {31'h0, ERR_ALINEACION}, 32'h0);
    check_eq("to_req_low", {31'h0, MEM_REQ}, 32'h0);
    check_eq("to_dato_r", DATO_R, last_dr);
    @(negedge CLK);
    check_eq("to_err_clr", {31'h0, ERR_TIMEOUT}, 32'h0);
    check_eq("to_req_after", {31'h0, MEM_REQ}, 32'h0);
    run_txn(1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h2468_ACE0, 3, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
